// File: rtl/fb_fill_engine.sv
`default_nettype none
// fb_fill_engine: framebuffer write-port arbiter and rectangle-fill engine.
// CPU accesses have priority; a starvation counter guarantees engine progress.
module fb_fill_engine #(
  parameter int STARVE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_en,
  input  logic [7:0]  cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [63:0] cpu_wrdata,
  output logic        cpu_gnt,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wrdata,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [19:0] hid_addr,
  output logic [63:0] hid_wrdata,
  output logic        busy,
  output logic        done
);

  localparam int                c_SC_W   = $clog2(STARVE + 2);
  localparam logic [c_SC_W-1:0] c_STARVE = c_SC_W'(STARVE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [15:0]        r_base;
  logic [15:0]        r_stride;
  logic [11:0]        r_width;
  logic [11:0]        r_height;
  logic [63:0]        r_pattern;
  logic [11:0]        r_x;
  logic [11:0]        r_y;
  logic [15:0]        r_lb;
  logic [c_SC_W-1:0]  r_starve;
  logic               r_busy;
  logic               r_done;

  logic        w_eng_req;
  logic        w_eng_gnt;
  logic        w_cpu_gnt;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic        w_last_x;
  logic        w_last_y;
  logic        w_zero;
  logic [15:0] w_word;

  assign w_eng_req = (r_state == S_FILL);
  assign w_eng_gnt = w_eng_req && (!cpu_en || (r_starve == c_STARVE));
  // Gated by reset so the port is fully quiet while rst_ni is held low.
  assign w_cpu_gnt = rst_ni && cpu_en && !w_eng_gnt;

  assign w_ctrl_wr = cfg_we && (cfg_addr == 3'd6);
  assign w_abort   = w_ctrl_wr && cfg_wrdata[1];
  assign w_start   = w_ctrl_wr && cfg_wrdata[0] && !cfg_wrdata[1];
  assign w_zero    = (r_width == 12'd0) || (r_height == 12'd0);
  assign w_last_x  = (r_x == r_width - 12'd1);
  assign w_last_y  = (r_y == r_height - 12'd1);
  assign w_word    = r_lb + {4'd0, r_x};

  assign cpu_gnt = w_cpu_gnt;
  assign busy    = r_busy;
  assign done    = r_done;

  always_comb begin
    hid_en     = 1'b0;
    hid_we     = 8'h00;
    hid_addr   = 20'h00000;
    hid_wrdata = 64'h0;
    if (w_eng_gnt) begin
      hid_en     = 1'b1;
      hid_we     = 8'hFF;
      hid_addr   = {1'b1, w_word, 3'b000};
      hid_wrdata = r_pattern;
    end else if (w_cpu_gnt) begin
      hid_en     = 1'b1;
      hid_we     = cpu_we;
      hid_addr   = cpu_addr;
      hid_wrdata = cpu_wrdata;
    end
  end

  // Geometry and pattern are frozen while a fill is in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base    <= 16'h0;
      r_stride  <= 16'h0;
      r_width   <= 12'h0;
      r_height  <= 12'h0;
      r_pattern <= 64'h0;
    end else if (cfg_we && (r_state == S_IDLE)) begin
      case (cfg_addr)
        3'd0:    r_base            <= cfg_wrdata[15:0];
        3'd1:    r_stride          <= cfg_wrdata[15:0];
        3'd2:    r_width           <= cfg_wrdata[11:0];
        3'd3:    r_height          <= cfg_wrdata[11:0];
        3'd4:    r_pattern[31:0]   <= cfg_wrdata;
        3'd5:    r_pattern[63:32]  <= cfg_wrdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_x      <= 12'h0;
      r_y      <= 12'h0;
      r_lb     <= 16'h0;
      r_starve <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if ((r_state != S_FILL) || w_eng_gnt) begin
        r_starve <= '0;
      end else if (cpu_en) begin
        r_starve <= r_starve + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_x    <= 12'h0;
            r_y    <= 12'h0;
            r_lb   <= r_base;
            r_busy <= 1'b1;
            if (w_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_eng_gnt) begin
            if (!w_last_x) begin
              r_x <= r_x + 12'd1;
            end else begin
              r_x  <= 12'h0;
              r_lb <= r_lb + r_stride;
              if (w_last_y) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_y <= r_y + 12'd1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_fill_engine.sv
`default_nettype none
// tb_fb_fill_engine: directed test of fb_fill_engine with a port-write scoreboard.
module tb_fb_fill_engine;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_en = 1'b0;
  logic [7:0]  cpu_we = 8'h00;
  logic [19:0] cpu_addr = 20'h0;
  logic [63:0] cpu_wrdata = 64'h0;
  logic        cpu_gnt;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_wrdata = 32'h0;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [19:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic        busy;
  logic        done;

  fb_fill_engine #(.STARVE(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
    .cpu_gnt(cpu_gnt),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wrdata(cfg_wrdata),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .busy(busy), .done(done)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  we;
    logic [19:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_seen   = 0;
  logic [63:0] pat;

  // Every port access seen at the falling edge must match the next expected one.
  always @(negedge clk_i) begin
    if (hid_en === 1'b1) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_write obs addr=%h we=%h data=%h exp none", hid_addr, hid_we, hid_wrdata);
      end else begin
        e = exp_q.pop_front();
        assert (hid_addr === e.addr && hid_we === e.we && hid_wrdata === e.data) else begin
          n_fail++;
          $error("FAIL port_write#%0d obs addr=%h we=%h data=%h exp addr=%h we=%h data=%h",
                 n_seen, hid_addr, hid_we, hid_wrdata, e.addr, e.we, e.data);
        end
      end
      n_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we     = 1'b1;
    cfg_addr   = a;
    cfg_wrdata = d;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic push_eng(input logic [15:0] word);
    exp_q.push_back('{we: 8'hFF, addr: {1'b1, word, 3'b000}, data: pat});
  endtask

  task automatic setup(input logic [15:0] b, input logic [15:0] s,
                       input logic [11:0] w, input logic [11:0] h);
    cfg_write(3'd0, {16'h0, b});
    cfg_write(3'd1, {16'h0, s});
    cfg_write(3'd2, {20'h0, w});
    cfg_write(3'd3, {20'h0, h});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {63'h0, done}, 64'h1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hid_en", {63'h0, hid_en}, 64'h0);
    chk("rst_hid_we", {56'h0, hid_we}, 64'h0);
    chk("rst_hid_addr", {44'h0, hid_addr}, 64'h0);
    chk("rst_hid_wrdata", hid_wrdata, 64'h0);
    chk("rst_cpu_gnt", {63'h0, cpu_gnt}, 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic fill
    pat = 64'hDEADBEEF_01234567;
    setup(16'h0100, 16'h0040, 12'd3, 12'd2);
    cfg_write(3'd4, pat[31:0]);
    cfg_write(3'd5, pat[63:32]);
    foreach (exp_q[i]) ;
    push_eng(16'h0100); push_eng(16'h0101); push_eng(16'h0102);
    push_eng(16'h0140); push_eng(16'h0141); push_eng(16'h0142);
    chk("basic_busy_before", {63'h0, busy}, 64'h0);
    cfg_write(3'd6, 32'h1);
    chk("basic_busy_n1", {63'h0, busy}, 64'h1);
    #1;
    chk("basic_first_addr", {44'h0, hid_addr}, 64'h80800);
    for (int i = 0; i < 5; i++) tick();
    chk("basic_done_early", {63'h0, done}, 64'h0);
    tick();
    chk("basic_done", {63'h0, done}, 64'h1);
    chk("basic_busy_done", {63'h0, busy}, 64'h1);
    chk("basic_drain", exp_q.size(), 64'h0);
    tick();
    chk("basic_done_clr", {63'h0, done}, 64'h0);
    chk("basic_busy_clr", {63'h0, busy}, 64'h0);

    // Zero size
    cfg_write(3'd2, 32'h0);
    cfg_write(3'd6, 32'h1);
    chk("zero_done", {63'h0, done}, 64'h1);
    chk("zero_busy", {63'h0, busy}, 64'h1);
    tick();
    chk("zero_busy_clr", {63'h0, busy}, 64'h0);
    chk("zero_done_clr", {63'h0, done}, 64'h0);

    // Starvation: continuous CPU load during a 2x1 fill
    cfg_write(3'd2, 32'd2);
    cfg_write(3'd3, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) push_eng(16'h0100);
      else if (i == 9) push_eng(16'h0101);
      else exp_q.push_back('{we: 8'h0F, addr: 20'h01230, data: 64'h1111_2222_3333_0000 + i});
    end
    cfg_write(3'd6, 32'h1);
    cpu_en = 1'b1;
    cpu_we = 8'h0F;
    cpu_addr = 20'h01230;
    for (int i = 0; i < 10; i++) begin
      cpu_wrdata = 64'h1111_2222_3333_0000 + i;
      #1;
      chk($sformatf("starve_gnt%0d", i), {63'h0, cpu_gnt}, (i == 4 || i == 9) ? 64'h0 : 64'h1);
      if (i == 3) chk("starve_done_mid", {63'h0, done}, 64'h0);
      tick();
    end
    cpu_en = 1'b0;
    chk("starve_done", {63'h0, done}, 64'h1);
    chk("starve_drain", exp_q.size(), 64'h0);
    tick();

    // Abort after 5 writes, then refill from BASE
    setup(16'h0200, 16'h0010, 12'd4, 12'd4);
    push_eng(16'h0200); push_eng(16'h0201); push_eng(16'h0202);
    push_eng(16'h0203); push_eng(16'h0210);
    cfg_write(3'd6, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    cfg_write(3'd6, 32'h2);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    #1;
    chk("abort_hid_en", {63'h0, hid_en}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", {63'h0, done}, 64'h0);
      tick();
    end
    chk("abort_drain", exp_q.size(), 64'h0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) push_eng(16'h0200 + 16'(y * 16 + x));
    cfg_write(3'd6, 32'h1);
    wait_done(40, "refill_done");
    chk("refill_drain", exp_q.size(), 64'h0);
    tick();

    // Busy protection and address wrap
    setup(16'hFFFF, 16'h0010, 12'd2, 12'd2);
    push_eng(16'hFFFF); push_eng(16'h0000); push_eng(16'h000F); push_eng(16'h0010);
    cfg_write(3'd6, 32'h1);
    cfg_write(3'd2, 32'd5);
    cfg_write(3'd6, 32'h1);
    tick();
    tick();
    chk("wrap_done", {63'h0, done}, 64'h1);
    chk("wrap_drain", exp_q.size(), 64'h0);
    tick();
    tick();
    chk("wrap_no_restart", {63'h0, busy}, 64'h0);

    // Reset mid-fill
    setup(16'h0300, 16'h0010, 12'd4, 12'd4);
    push_eng(16'h0300); push_eng(16'h0301); push_eng(16'h0302);
    cfg_write(3'd6, 32'h1);
    tick();
    tick();
    #5;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_done", {63'h0, done}, 64'h0);
    chk("mid_rst_hid_en", {63'h0, hid_en}, 64'h0);
    chk("mid_rst_hid_addr", {44'h0, hid_addr}, 64'h0);
    chk("mid_rst_drain", exp_q.size(), 64'h0);
    tick();
    rst_ni = 1'b1;
    exp_q.push_back('{we: 8'h00, addr: 20'hABCD8, data: 64'h5A5A_5A5A_5A5A_5A5A});
    cpu_en = 1'b1;
    cpu_we = 8'h00;
    cpu_addr = 20'hABCD8;
    cpu_wrdata = 64'h5A5A_5A5A_5A5A_5A5A;
    #1;
    chk("post_rst_cpu_gnt", {63'h0, cpu_gnt}, 64'h1);
    tick();
    cpu_en = 1'b0;
    chk("post_rst_no_done", {63'h0, done}, 64'h0);
    chk("post_rst_drain", exp_q.size(), 64'h0);
    // Geometry cleared by reset: a start is a zero-size fill
    cfg_write(3'd6, 32'h1);
    chk("post_rst_zero_done", {63'h0, done}, 64'h1);
    tick();
    tick();
    chk("final_drain", exp_q.size(), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
